// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch slice.
//   PC_W / INSTR_W   : address and instruction word widths
//   FETCH_BUF_DEPTH  : entries in the decode-side fetch buffer
//   fetch_state_e    : fetch sequencer states
//   fetch_entry_t    : one buffered fetch {pc, instr}
package fetch_pkg;

    localparam int unsigned PC_W            = 16;
    localparam int unsigned INSTR_W         = 16;
    localparam int unsigned FETCH_BUF_DEPTH = 2;

    typedef enum logic [1:0] {
        StIdle,  // out of reset, nothing issued yet
        StReq,   // request outstanding, response will be kept
        StFull,  // buffer full, no request on the bus
        StDrop   // request outstanding, response will be thrown away
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // Instructions are word-aligned on a 4-byte stride.
    function automatic logic pc_misaligned(input logic [PC_W-1:0] p);
        return p[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-side bus bundle: instruction-memory req/ack channel plus the
// decode valid/ready channel.
//   master : the fetch unit (drives imem_req/imem_addr and the instr_* outputs)
//   slave  : memory + decode side (drives imem_ack/imem_rdata and instr_ready)
interface pc_fetch_if;
    import fetch_pkg::*;

    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;

    logic               instr_valid;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    instr_pc;
    logic               instr_ready;

    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, instr_ready
    );

    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, instr_ready
    );

endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, instr} entries feeding decode.
//   clk, rst     : clock, async active-high reset
//   push_i/data  : write one entry (accepted when not full, or full with pop)
//   pop_i        : remove the head (ignored when empty)
//   flush_i      : drop all entries; overrides push and pop
//   head_o       : current head entry (meaningless while empty_o)
//   full_o, empty_o, count_o : occupancy status
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int unsigned Depth = FETCH_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  fetch_entry_t               push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output fetch_entry_t               head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(Depth+1)-1:0] count_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    fetch_entry_t    mem_q [Depth];
    fetch_entry_t    mem_d [Depth];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && !empty_o;
        do_push  = push_i && (!full_o || do_pop);

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + 1'b1;
            end else if (!do_push && do_pop) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/pc_fetch.sv
// Program-counter register and instruction-fetch sequencer.
//   clk, rst   : clock, async active-high reset
//   pc         : current PC, to the next-PC adjust block
//   next_pc    : adjusted PC from the adjust block (pc+4 or a target)
//   redirect   : taken jump/branch; flush and refetch from next_pc
//   align_err  : sticky misaligned-PC flag
//   bus        : imem req/ack channel and decode valid/ready channel
// Optional feature macro: PC_FETCH_ALIGN_CHECK_EN builds the alignment check;
// without it align_err is tied low.
module pc_fetch
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] next_pc,
    input  logic            redirect,
    output logic            align_err,
    pc_fetch_if.master      bus
);

    localparam int unsigned CntW = $clog2(FETCH_BUF_DEPTH + 1);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] addr_q, addr_d;
    logic            req_q, req_d;

    fetch_entry_t    buf_head;
    fetch_entry_t    push_data;
    logic            buf_full, buf_empty;
    logic [CntW-1:0] buf_count;
    logic            push, pop, fills;

    assign pop       = bus.instr_ready && !buf_empty;
    assign push_data = '{pc: addr_q, instr: bus.imem_rdata};
    // A push without a simultaneous pop into the last free slot fills the buffer.
    assign fills     = (buf_count == CntW'(FETCH_BUF_DEPTH - 1)) && !pop;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        push    = 1'b0;

        unique case (state_q)
            StIdle: begin
                state_d = StReq;
                req_d   = 1'b1;
                addr_d  = pc_q;
            end
            StReq: begin
                if (bus.imem_ack) begin
                    push = 1'b1;
                    pc_d = next_pc;
                    if (fills) begin
                        state_d = StFull;
                        req_d   = 1'b0;
                    end else begin
                        addr_d = next_pc;
                    end
                end
            end
            StFull: begin
                if (pop) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            StDrop: begin
                // Stale response retires here; pc already holds the target.
                if (bus.imem_ack) begin
                    state_d = StReq;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            default: begin
                state_d = StIdle;
                req_d   = 1'b0;
            end
        endcase

        // Redirect overrides everything, including a same-cycle ack.
        if (redirect) begin
            push = 1'b0;
            pc_d = next_pc;
            if (req_q && !bus.imem_ack) begin
                // Bus request must stay stable until the memory answers.
                state_d = StDrop;
                req_d   = 1'b1;
                addr_d  = addr_q;
            end else begin
                state_d = StReq;
                req_d   = 1'b1;
                addr_d  = next_pc;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

`ifdef PC_FETCH_ALIGN_CHECK_EN
    logic align_q, align_d;
    logic pc_load;

    assign pc_load = redirect || (state_q == StReq && bus.imem_ack);
    assign align_d = align_q || (pc_load && pc_misaligned(next_pc));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            align_q <= 1'b0;
        end else begin
            align_q <= align_d;
        end
    end

    assign align_err = align_q;
`else
    assign align_err = 1'b0;
`endif

    fetch_buffer #(
        .Depth (FETCH_BUF_DEPTH)
    ) u_fetch_buffer (
        .clk         (clk),
        .rst         (rst),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (redirect),
        .head_o      (buf_head),
        .full_o      (buf_full),
        .empty_o     (buf_empty),
        .count_o     (buf_count)
    );

    assign pc              = pc_q;
    assign bus.imem_req    = req_q;
    assign bus.imem_addr   = addr_q;
    assign bus.instr_valid = !buf_empty;
    assign bus.instr       = buf_head.instr;
    assign bus.instr_pc    = buf_head.pc;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: a per-cycle vector table plus a hand-written
// mid-operation reset sequence. Memory returns addr ^ 16'hBEEF as data; the
// adjust block is modelled as pc+4, or the vector's target on redirect.
module tb_pc_fetch;
    import fetch_pkg::*;

`ifdef PC_FETCH_ALIGN_CHECK_EN
    localparam logic AlignOn = 1'b1;
`else
    localparam logic AlignOn = 1'b0;
`endif
    localparam int NVec = 27;

    typedef struct {
        logic        ack;
        logic        rdy;
        logic        redir;
        logic [15:0] tgt;
        logic        e_req;
        logic [15:0] e_addr;
        logic        e_valid;
        logic [15:0] e_ipc;
        logic [15:0] e_pc;
        logic        e_align;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] pc;
    logic [15:0] next_pc;
    logic        redirect = 1'b0;
    logic [15:0] tgt = 16'h0000;
    logic        align_err;

    pc_fetch_if bus ();

    pc_fetch #(
        .RESET_PC (16'h0000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc        (pc),
        .next_pc   (next_pc),
        .redirect  (redirect),
        .align_err (align_err),
        .bus       (bus.master)
    );

    always #5 clk = ~clk;

    assign next_pc        = redirect ? tgt : pc + 16'd4;
    assign bus.imem_rdata = bus.imem_addr ^ 16'hBEEF;

    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t vecs [NVec];

    function automatic vec_t mk(input logic ack, input logic rdy, input logic redir,
                                input logic [15:0] t, input logic e_req,
                                input logic [15:0] e_addr, input logic e_valid,
                                input logic [15:0] e_ipc, input logic [15:0] e_pc,
                                input logic e_align);
        vec_t v;
        v.ack = ack; v.rdy = rdy; v.redir = redir; v.tgt = t;
        v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
        v.e_ipc = e_ipc; v.e_pc = e_pc; v.e_align = e_align;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " pc"}, pc, 16'h0000);
        chk({tag, " imem_req"}, {15'd0, bus.imem_req}, 16'd0);
        chk({tag, " imem_addr"}, bus.imem_addr, 16'h0000);
        chk({tag, " instr_valid"}, {15'd0, bus.instr_valid}, 16'd0);
        chk({tag, " instr"}, bus.instr, 16'h0000);
        chk({tag, " instr_pc"}, bus.instr_pc, 16'h0000);
        chk({tag, " align_err"}, {15'd0, align_err}, 16'd0);
    endtask

    initial begin
        //                ack  rdy  red  tgt       req  addr      vld  ipc       pc        align
        vecs[0]  = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        vecs[1]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0);
        vecs[2]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0004, 1'b1, 16'h0000, 16'h0004, 1'b0);
        vecs[3]  = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0008, 1'b1, 16'h0004, 16'h0008, 1'b0);
        vecs[4]  = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h000C, 1'b1, 16'h0008, 16'h000C, 1'b0);
        // decode stalls: two acks fill the buffer
        vecs[5]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h000C, 1'b0, 16'h0000, 16'h000C, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b1, 16'h000C, 16'h0010, 1'b0);
        vecs[7]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h000C, 16'h0014, 1'b0);
        vecs[8]  = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h000C, 16'h0014, 1'b0);
        vecs[9]  = mk(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0014, 1'b1, 16'h0010, 16'h0014, 1'b0);
        // redirect with request outstanding, ack three cycles later
        vecs[10] = mk(1'b0, 1'b0, 1'b1, 16'h0040, 1'b1, 16'h0014, 1'b1, 16'h0010, 16'h0014, 1'b0);
        vecs[11] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0014, 1'b0, 16'h0000, 16'h0040, 1'b0);
        vecs[12] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0014, 1'b0, 16'h0000, 16'h0040, 1'b0);
        vecs[13] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0014, 1'b0, 16'h0000, 16'h0040, 1'b0);
        vecs[14] = mk(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0040, 1'b0);
        // redirect and ack in the same cycle
        vecs[15] = mk(1'b1, 1'b0, 1'b1, 16'h0080, 1'b1, 16'h0044, 1'b1, 16'h0040, 16'h0044, 1'b0);
        vecs[16] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0080, 1'b0, 16'h0000, 16'h0080, 1'b0);
        vecs[17] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0080, 1'b0, 16'h0000, 16'h0080, 1'b0);
        vecs[18] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0084, 1'b1, 16'h0080, 16'h0084, 1'b0);
        // 16-bit wrap of the adjusted PC
        vecs[19] = mk(1'b0, 1'b1, 1'b1, 16'hFFFC, 1'b1, 16'h0084, 1'b0, 16'h0000, 16'h0084, 1'b0);
        vecs[20] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0084, 1'b0, 16'h0000, 16'hFFFC, 1'b0);
        vecs[21] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hFFFC, 1'b0, 16'h0000, 16'hFFFC, 1'b0);
        // misaligned target
        vecs[22] = mk(1'b0, 1'b1, 1'b1, 16'h0002, 1'b1, 16'h0000, 1'b1, 16'hFFFC, 16'h0000, 1'b0);
        vecs[23] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0002, AlignOn);
        vecs[24] = mk(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0002, 1'b0, 16'h0000, 16'h0002, AlignOn);
        vecs[25] = mk(1'b1, 1'b1, 1'b1, 16'h0100, 1'b1, 16'h0006, 1'b1, 16'h0002, 16'h0006, AlignOn);
        vecs[26] = mk(1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0100, AlignOn);

        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b0;

        @(negedge clk);
        @(negedge clk);
        n_vec++;
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < NVec; i++) begin
            if (i > 0) @(negedge clk);
            n_vec++;
            chk($sformatf("v%0d imem_req", i), {15'd0, bus.imem_req}, {15'd0, vecs[i].e_req});
            if (vecs[i].e_req)
                chk($sformatf("v%0d imem_addr", i), bus.imem_addr, vecs[i].e_addr);
            chk($sformatf("v%0d instr_valid", i), {15'd0, bus.instr_valid},
                {15'd0, vecs[i].e_valid});
            if (vecs[i].e_valid) begin
                chk($sformatf("v%0d instr_pc", i), bus.instr_pc, vecs[i].e_ipc);
                chk($sformatf("v%0d instr", i), bus.instr, vecs[i].e_ipc ^ 16'hBEEF);
            end
            chk($sformatf("v%0d pc", i), pc, vecs[i].e_pc);
            chk($sformatf("v%0d align_err", i), {15'd0, align_err}, {15'd0, vecs[i].e_align});
            bus.imem_ack    = vecs[i].ack;
            bus.instr_ready = vecs[i].rdy;
            redirect        = vecs[i].redir;
            tgt             = vecs[i].tgt;
        end

        // Reset while the fetch of 0x0100 is outstanding.
        @(negedge clk);
        bus.imem_ack    = 1'b0;
        bus.instr_ready = 1'b1;
        redirect        = 1'b0;
        n_vec++;
        chk("pre-reset imem_req", {15'd0, bus.imem_req}, 16'd1);
        rst = 1'b1;
        #1;
        n_vec++;
        chk_reset_outputs("async reset");
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        chk("post-reset idle imem_req", {15'd0, bus.imem_req}, 16'd0);

        begin
            int waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!bus.imem_req && waited < 4);
            n_vec++;
            chk("post-reset req latency", 16'(waited), 16'd1);
            chk("post-reset imem_addr", bus.imem_addr, 16'h0000);
        end
        bus.imem_ack = 1'b1;
        @(negedge clk);
        bus.imem_ack = 1'b0;
        n_vec++;
        chk("post-reset instr_valid", {15'd0, bus.instr_valid}, 16'd1);
        chk("post-reset instr_pc", bus.instr_pc, 16'h0000);
        chk("post-reset instr", bus.instr, 16'hBEEF);
        chk("post-reset pc", pc, 16'h0004);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter register and instruction-fetch sequencer for the 16-bit RISC core; it is the consumer of the next-PC adjust logic. It presents the current `pc` to the adjust logic and loads the returned `next_pc` each time a fetch completes or a redirect occurs. It issues fetches to instruction memory over a req/ack handshake and buffers fetched words in a 2-entry queue for decode, which reads through a valid/ready handshake.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-high reset.
- `pc` out 16: current PC, driven to the adjust block's PC input.
- `next_pc` in 16: adjusted PC returned by the adjust block. This is PC+4, the jump target, or the branch target, depending on the decoder's select.
- `redirect` in 1: decoder resolved a taken jump/branch this cycle; `next_pc` carries the target.
- `imem_req` out 1: fetch request.
- `imem_addr` out 16: fetch address; stable while `imem_req` is high.
- `imem_ack` in 1: one-cycle pulse; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 16: fetched instruction word.
- `instr_valid` out 1: buffer head is valid.
- `instr` out 16: buffered instruction word.
- `instr_pc` out 16: PC the buffered instruction was fetched from.
- `instr_ready` in 1: decode accepts the head; transfer occurs when valid && ready.
- `align_err` out 1: sticky misaligned-fetch flag (see Configuration).

## Operation
- FSM states:
  - IDLE: after reset.
  - REQ: request outstanding.
  - FULL: buffer full, no request.
  - DROP: outstanding request whose response must be discarded.
- IDLE → REQ unconditionally on the first clock after reset release. Entering REQ latches `imem_addr <= pc`.
- REQ + `imem_ack`:
  - Push {`imem_addr`, `imem_rdata`} into the buffer and set `pc <= next_pc`.
  - Next state is REQ with a new address if the buffer will not be full, otherwise FULL.
- FULL → REQ in the cycle after a pop frees a slot.
- `redirect` in any state:
  - Flush the buffer (`instr_valid` low next cycle) and set `pc <= next_pc`.
  - If a request is outstanding without ack, go to DROP. `imem_req`/`imem_addr` stay held until ack, the response is discarded, then REQ with the new `pc`.
- `redirect` and `imem_ack` in the same cycle: redirect wins; data is discarded; go to REQ with the target.
- Push and pop in the same cycle are both performed; occupancy is unchanged.
- The buffer is strictly FIFO; `instr`/`instr_pc` are don't-care while `instr_valid` is low.
- PC arithmetic belongs to the adjust block only; 16-bit wrap-around (16'hFFFC + 4 = 16'h0000) is passed through unmodified.
- Reset mid-operation: any outstanding request is abandoned; memory must tolerate `imem_req` dropping.

## Timing
- Reset values: `pc`=RESET_PC, `imem_req`=0, `imem_addr`=RESET_PC, `instr_valid`=0, `instr`=0, `instr_pc`=0, `align_err`=0.
- First `imem_req` high in the first cycle after `rst` deasserts.
- Ack in cycle n → `instr_valid` high in cycle n+1. With an immediate ack, back-to-back fetches sustain 1 word/cycle.
- `imem_req` is deasserted for exactly the cycle following an ack only when that ack fills the buffer.
- Redirect in cycle n → `pc` = target in n+1; request for the target is issued in n+1, or after the pending ack in DROP.
- All outputs are registered; there is no combinational path from `imem_ack`/`instr_ready` to outputs.

## Configuration
- `PC_FETCH_ALIGN_CHECK_EN` defined: loading a `pc` with bits [1:0] != 0 sets `align_err` sticky until reset. The fetch is still issued.
- Not defined: `align_err` is tied to 0 and no check logic is built.

## Structure
- Shared package `fetch_pkg`: FSM state enum (IDLE, REQ, FULL, DROP), `PC_W`=16, `INSTR_W`=16, `FETCH_BUF_DEPTH`=2.
- Sub-module `fetch_buffer`: 2-entry FIFO of {pc, instr} with push, pop, flush, full, and empty. `pc_fetch` holds the FSM and PC register.

## Test plan
- Reset release, memory acks every cycle, `instr_ready`=1, `next_pc`=pc+4 → instructions at PCs 0, 4, 8, … with `instr_valid` from cycle 2.
- `instr_ready`=0 → after 2 acks `imem_req` drops and state is FULL. One pop → request re-issued next cycle.
- `redirect` with `next_pc`=16'h0040 while REQ is outstanding and ack arrives 3 cycles later → that word is discarded; next fetch address is 0x0040; buffer is flushed.
- `redirect` and `imem_ack` in the same cycle → data is not pushed; next `imem_addr`=target.
- `next_pc`=16'h0002 with the macro defined → `align_err` set and held; with the macro undefined it stays 0.
- `rst` asserted while a request is outstanding → outputs immediately at reset values; first fetch on release is at RESET_PC.
